// File: rtl/mc_seq_regs.sv
// rtl/mc_seq_regs.sv - multicycle MIPS sequencer state and datapath registers
module mc_seq_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ns3,
  input  logic             ns2,
  input  logic             ns1,
  input  logic             ns0,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             IorD,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             IRWrite,
  input  logic [1:0]       PCSource,
  input  logic             zero,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      rd_a,
  input  logic [31:0]      rd_b,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             s3,
  output logic             s2,
  output logic             s1,
  output logic             s0,
  output logic             op5,
  output logic             op4,
  output logic             op3,
  output logic             op2,
  output logic             op1,
  output logic             op0,
  output logic [31:0]      ir,
  output logic [31:0]      pc,
  output logic [31:0]      mdr,
  output logic [31:0]      a_q,
  output logic [31:0]      b_q,
  output logic [31:0]      alu_out,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             state_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMREAD = 4'd3,
    S_LW_WB   = 4'd4,
    S_SW      = 4'd5,
    S_EXEC    = 4'd6,
    S_R_WB    = 4'd7,
    S_BEQ     = 4'd8,
    S_J       = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [31:0]      a_d, b_d, alu_out_q, alu_out_d;
  logic             state_err_q, state_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [3:0]       ns;
  logic             stall, advance, ns_legal, pc_en;

  assign ns       = {ns3, ns2, ns1, ns0};
  assign mem_req  = MemRead | MemWrite;
  assign mem_we   = MemWrite;
  assign mem_addr = IorD ? alu_out_q : pc_q;
  assign mem_wdata = b_q;
  assign stall    = mem_req & ~mem_ready;
  assign advance  = ~stall;
  assign ns_legal = (ns <= 4'd9);
  assign pc_en    = PCWrite | (PCWriteCond & zero);

  assign {s3, s2, s1, s0}                = state_q;
  assign {op5, op4, op3, op2, op1, op0}  = ir_q[31:26];
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign mdr       = mdr_q;
  assign alu_out   = alu_out_q;
  assign state_err = state_err_q;
  assign retired   = retired_q;

  // All next values are computed from pre-edge registers, so a jump sees the old pc and ir.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_out_d   = alu_out_q;
    state_err_d = state_err_q;
    retired_d   = retired_q;
    if (advance) begin
      state_d   = ns_legal ? state_t'(ns) : S_FETCH;
      a_d       = rd_a;
      b_d       = rd_b;
      alu_out_d = alu_result;
      if (!ns_legal) state_err_d = 1'b1;
      // Only a genuine return to fetch retires an instruction, not an illegal-state recovery.
      if (ns_legal && ns == 4'd0 && state_q != S_FETCH) retired_d = retired_q + CNT_W'(1);
      if (pc_en) begin
        case (PCSource)
          2'b00:   pc_d = alu_result;
          2'b01:   pc_d = alu_out_q;
          2'b10:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
          default: pc_d = pc_q;
        endcase
      end
    end
    if (IRWrite & mem_ready) ir_d = mem_rdata;
    if (MemRead & mem_ready) mdr_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      mdr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_out_q   <= '0;
      state_err_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_out_q   <= alu_out_d;
      state_err_q <= state_err_d;
      retired_q   <= retired_d;
    end
  end

endmodule
